// File: rtl/data_ram_sweep_if.sv
// data_ram_sweep_if: load/store access bus and status of the data RAM clear engine.
// Optional macro DATA_RAM_PARITY_EN adds the rd_perr read-parity status.
interface data_ram_sweep_if #(
   parameter int unsigned W  = 32,
   parameter int unsigned AW = 5
);
   localparam int unsigned NB = W / 8;

   logic          en;
   logic          wr;
   logic [AW-1:0] addr;
   logic [W-1:0]  din;
   logic [NB-1:0] be;
   logic          clr_req;
   logic [W-1:0]  dout;
   logic          rd_valid;
   logic          busy;
   logic          clr_done;
   logic          err;
`ifdef DATA_RAM_PARITY_EN
   logic [NB-1:0] rd_perr;
`endif

   // Requester side (load/store unit and control)
   modport master (
      output en, wr, addr, din, be, clr_req,
`ifdef DATA_RAM_PARITY_EN
      input  rd_perr,
`endif
      input  dout, rd_valid, busy, clr_done, err
   );

   // RAM side
   modport slave (
      input  en, wr, addr, din, be, clr_req,
`ifdef DATA_RAM_PARITY_EN
      output rd_perr,
`endif
      output dout, rd_valid, busy, clr_done, err
   );
endinterface

// File: rtl/data_ram_sweep.sv
// data_ram_sweep: single-port synchronous data RAM with byte enables and a
// self-completing clear sweep (one row per clock, started by reset or clr_req).
// Optional macro DATA_RAM_PARITY_EN stores even parity per byte and reports
// per-byte parity mismatches on reads via rd_perr.
module data_ram_sweep #(
   parameter int unsigned   W    = 32,
   parameter int unsigned   AW   = 5,
   parameter logic [W-1:0]  FILL = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   data_ram_sweep_if.slave    bus
);
   localparam int unsigned NB    = W / 8;
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t        r_state;
   logic [AW-1:0] r_ptr;
   logic [W-1:0]  r_mem [DEPTH];
   logic [W-1:0]  r_dout;
   logic          r_rd_valid;
   logic          r_busy;
   logic          r_clr_done;
   logic          r_err;

`ifdef DATA_RAM_PARITY_EN
   // Even parity of each byte of a word
   function automatic logic [NB-1:0] byte_par(input logic [W-1:0] d);
      logic [NB-1:0] p;
      p = '0;
      for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   localparam logic [NB-1:0] FILL_PAR = byte_par(FILL);

   logic [NB-1:0] r_par [DEPTH];
   logic [NB-1:0] r_rd_perr;
`endif

   // Sweep/access FSM, RAM array and registered status outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_CLEAR;
         r_ptr      <= '0;
         r_dout     <= '0;
         r_rd_valid <= 1'b0;
         r_clr_done <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b1;
         r_mem[0]   <= FILL;
`ifdef DATA_RAM_PARITY_EN
         r_par[0]   <= FILL_PAR;
         r_rd_perr  <= '0;
`endif
      end else begin
         r_rd_valid <= 1'b0;
         r_clr_done <= 1'b0;
         r_err      <= 1'b0;
`ifdef DATA_RAM_PARITY_EN
         r_rd_perr  <= '0;
`endif
         case (r_state)
            S_CLEAR: begin
               // Accesses are rejected while sweeping; clr_req is ignored
               r_mem[r_ptr] <= FILL;
`ifdef DATA_RAM_PARITY_EN
               r_par[r_ptr] <= FILL_PAR;
`endif
               r_ptr <= r_ptr + AW'(1);
               if (bus.en) r_err <= 1'b1;
               if (r_ptr == AW'(DEPTH - 1)) begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_clr_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.clr_req) begin
                  // Clear request wins over a simultaneous access
                  r_state <= S_CLEAR;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
                  if (bus.en) r_err <= 1'b1;
               end else if (bus.en) begin
                  if (bus.wr) begin
                     for (int i = 0; i < NB; i++) begin
                        if (bus.be[i]) begin
                           r_mem[bus.addr][8*i +: 8] <= bus.din[8*i +: 8];
`ifdef DATA_RAM_PARITY_EN
                           r_par[bus.addr][i] <= ^bus.din[8*i +: 8];
`endif
                        end
                     end
                  end else begin
                     r_dout     <= r_mem[bus.addr];
                     r_rd_valid <= 1'b1;
`ifdef DATA_RAM_PARITY_EN
                     for (int i = 0; i < NB; i++)
                        r_rd_perr[i] <= (^r_mem[bus.addr][8*i +: 8]) ^ r_par[bus.addr][i];
`endif
                  end
               end
            end
         endcase
      end
   end

   assign bus.dout     = r_dout;
   assign bus.rd_valid = r_rd_valid;
   assign bus.busy     = r_busy;
   assign bus.clr_done = r_clr_done;
   assign bus.err      = r_err;
`ifdef DATA_RAM_PARITY_EN
   assign bus.rd_perr  = r_rd_perr;
`endif

endmodule

// File: tb/tb_data_ram_sweep.sv
// tb_data_ram_sweep: directed bench for data_ram_sweep (W=32, AW=5, FILL=0).
// Read results are checked against a queue of expected words.
module tb_data_ram_sweep;
   logic clk;
   logic rst;

   data_ram_sweep_if #(.W(32), .AW(5)) bus ();

   data_ram_sweep #(.W(32), .AW(5), .FILL(32'h0)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.en      = 1'b0;
      bus.wr      = 1'b0;
      bus.addr    = '0;
      bus.din     = '0;
      bus.be      = '0;
      bus.clr_req = 1'b0;
   endtask

   // One clock; any read result produced is scored against the queue
   task automatic step();
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (bus.rd_valid === 1'b1) begin
         if (exp_q.size() == 0) check("rd_valid_unexpected", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            check("dout", 64'(bus.dout), 64'(e));
         end
      end
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
      bus.en = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.din = d; bus.be = b;
      step();
      check("wr_err", 64'(bus.err), 64'd0);
      idle();
   endtask

   task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = a;
      exp_q.push_back(exp);
      step();
      check("rd_valid", 64'(bus.rd_valid), 64'd1);
      idle();
   endtask

   initial begin
      int n;
      int done_cnt;
      int cyc;
      idle();
      rst = 1'b1;

      // Power-on clear
      step();
      check("rst_busy", 64'(bus.busy), 64'd1);
      check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("rst_clr_done", 64'(bus.clr_done), 64'd0);
      check("rst_dout", 64'(bus.dout), 64'd0);
      bus.en = 1'b1; bus.wr = 1'b0;
      step();
      check("rst_err_held", 64'(bus.err), 64'd0);
      idle();
      rst = 1'b0;
      n = 0; done_cnt = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         step(); n++;
         if (bus.clr_done === 1'b1) done_cnt++;
      end
      check("busy_cycles", 64'(n), 64'd32);
      check("clr_done_last", 64'(bus.clr_done), 64'd1);
      step();
      check("clr_done_pulse", 64'(bus.clr_done), 64'd0);
      check("clr_done_count", 64'(done_cnt), 64'd1);
      do_read(5'd0, 32'h0);
      do_read(5'd15, 32'h0);
      do_read(5'd31, 32'h0);

      // Byte-enable writes, including be=0 no-op
      do_write(5'd2, 32'h11223344, 4'hF);
      do_write(5'd2, 32'hAABBCCDD, 4'b0101);
      do_read(5'd2, 32'h11BB33DD);
      do_write(5'd2, 32'hFFFFFFFF, 4'b0000);
      do_read(5'd2, 32'h11BB33DD);
      step();
      check("hold_dout", 64'(bus.dout), 64'h11BB33DD);
      check("hold_rd_valid", 64'(bus.rd_valid), 64'd0);

      // Back-to-back reads
      do_write(5'd16, 32'd167, 4'hF);
      do_write(5'd2, 32'd50, 4'hF);
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 5'd16; exp_q.push_back(32'd167);
      step();
      check("b2b_rdv0", 64'(bus.rd_valid), 64'd1);
      bus.addr = 5'd2; exp_q.push_back(32'd50);
      step();
      check("b2b_rdv1", 64'(bus.rd_valid), 64'd1);
      idle();
      step();
      check("b2b_rdv_end", 64'(bus.rd_valid), 64'd0);

      // Short reset still runs the full sweep
      do_write(5'd30, 32'h55AA55AA, 4'hF);
      rst = 1'b1; bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 5'd2;
      step();
      check("srst_err", 64'(bus.err), 64'd0);
      check("srst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("srst_busy", 64'(bus.busy), 64'd1);
      rst = 1'b0; idle();
      cyc = 0;
      repeat (4) begin step(); cyc++; end
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 5'd30;
      step(); cyc++;
      check("busy_rd_err", 64'(bus.err), 64'd1);
      check("busy_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("busy_rd_dout", 64'(bus.dout), 64'd0);
      idle();
      step(); cyc++;
      check("busy_err_pulse", 64'(bus.err), 64'd0);
      while (bus.clr_done !== 1'b1 && cyc < 100) begin step(); cyc++; end
      check("srst_sweep_len", 64'(cyc), 64'd32);
      check("srst_busy_end", 64'(bus.busy), 64'd0);
      do_read(5'd2, 32'h0);
      do_read(5'd30, 32'h0);

      // Clear request colliding with a write; second request ignored
      do_write(5'd30, 32'd205, 4'hF);
      bus.clr_req = 1'b1; bus.en = 1'b1; bus.wr = 1'b1;
      bus.addr = 5'd1; bus.din = 32'd7; bus.be = 4'hF;
      step();
      check("clr_coll_err", 64'(bus.err), 64'd1);
      check("clr_coll_busy", 64'(bus.busy), 64'd1);
      idle();
      cyc = 0;
      while (bus.clr_done !== 1'b1 && cyc < 100) begin
         if (cyc == 9) bus.clr_req = 1'b1;
         step(); cyc++;
         if (cyc == 10) begin
            check("clr_req_busy_err", 64'(bus.err), 64'd0);
            bus.clr_req = 1'b0;
         end
      end
      check("clr_sweep_len", 64'(cyc), 64'd32);
      do_read(5'd1, 32'h0);
      do_read(5'd30, 32'h0);

`ifdef DATA_RAM_PARITY_EN
      // Corrupt one stored bit of addr 4 byte 1
      do_write(5'd4, 32'h12345678, 4'hF);
      do_write(5'd5, 32'hCAFEF00D, 4'hF);
      dut.r_mem[4][9] = ~dut.r_mem[4][9];
      do_read(5'd4, 32'h12345478);
      check("perr_bad", 64'(bus.rd_perr), 64'h2);
      do_read(5'd5, 32'hCAFEF00D);
      check("perr_good", 64'(bus.rd_perr), 64'h0);
      step();
      check("perr_idle", 64'(bus.rd_perr), 64'h0);
`endif

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
